motor_ctrl_fsm: RTL and testbench
=================================

Name: motor_ctrl_fsm

Overview:
Parametrised successor to the single-motor up/down limit controller. Drives one bidirectional motor between an up and a down limit switch, with:
- a programmable dead-time before the motor is energised;
- a maximum-run timeout;
- a stop command;
- limit-conflict detection;
- a sticky fault state with an explicit clear.

It sits between the panel/command logic and the motor driver pins.

Parameters:
- CNT_W, 16, width of the shared dead-time/run-time down-counter.
- DEAD_TIME, 4, cycles with both motor outputs low before energising. Legal range is 1..2^CNT_W-1.
- MAX_RUN, 1000, maximum cycles a motor output may stay high before a timeout fault. Legal range is 1..2^CNT_W-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- activate  input  1  start request, level-sampled in IDLE.
- stop  input  1  abort motion; motor off, return to IDLE.
- up_limit  input  1  upper limit switch, active-high.
- dn_limit  input  1  lower limit switch, active-high.
- fault_clr  input  1  clears FAULT; ignored in other states.
- motor_up  output  1  registered drive, up direction.
- motor_dn  output  1  registered drive, down direction.
- ctrl_state  output  3  current state encoding.
- fault  output  1  high while in FAULT.
- fault_code  output  2  0=none, 1=timeout, 2=limit conflict. Held until fault_clr.
- busy  output  1  high in DEAD, RUN_UP and RUN_DN.

Behaviour:
- Reset (async, rst_n low):
  - ctrl_state=IDLE, all outputs 0, counter 0, dir 0.
  - Reset mid-motion drops both motor outputs immediately, with no dead-time.
- States: IDLE=0, DEAD=1, RUN_UP=2, RUN_DN=3, FAULT=4. All outputs are registered.
- Global rule: up_limit && dn_limit in IDLE/DEAD/RUN_* → FAULT with fault_code=2, motors 0. This has the highest priority.
- IDLE, when activate=1:
  - dir=DN if up_limit, else UP.
  - Load counter with DEAD_TIME-1 and go to DEAD.
  - stop has priority over activate in the same cycle (stay in IDLE).
- DEAD:
  - Motors 0; counter decrements each cycle.
  - stop=1 → IDLE.
  - At counter==0: go to RUN_UP or RUN_DN per dir, set the matching motor output on the same edge, load counter with MAX_RUN-1.
- Latency: activate high at edge T → DEAD from T+1 → motor output high from edge T+DEAD_TIME+1.
- RUN_UP / RUN_DN, priority order:
  1. conflict → FAULT.
  2. Target limit (up_limit for UP, dn_limit for DN) → motor 0, IDLE.
  3. stop → motor 0, IDLE.
  4. counter==0 → motor 0, FAULT, fault_code=1.
  5. Otherwise decrement.
- Run bound: the motor output is high for at most MAX_RUN cycles.
- The opposite limit asserting alone while running is ignored; the motor is leaving it.
- motor_up and motor_dn are never high simultaneously, and never high in consecutive cycles with opposite direction. Every start passes through DEAD.
- FAULT:
  - Motors 0, fault=1, fault_code held.
  - fault_clr=1 → IDLE and fault_code=0. If the conflict persists, FAULT is re-entered next cycle.
  - activate and stop are ignored.
- Counter: unsigned CNT_W bits, no wrap. The counter is only decremented when non-zero.

Decomposition:
- Package motor_pkg holds the state localparams (IDLE..FAULT), the fault code constants (FC_NONE/FC_TIMEOUT/FC_CONFLICT) and the dir encoding.
- One natural sub-module, motor_timer: a loadable CNT_W down-counter with load/en/value inputs and a zero flag. The FSM instantiates it once.

Test Plan:
- Basic up move (DEAD_TIME=4, MAX_RUN=100, limits 0):
  - activate pulse at cycle 10 → motor_up rises at cycle 15.
  - up_limit at cycle 40 → motor_up low at 41, state IDLE.
- Down move from top:
  - up_limit=1, activate → DEAD for 4 cycles, then motor_dn=1.
  - dn_limit=1 → motor_dn=0, IDLE; motor_up stays 0 throughout.
- Timeout (MAX_RUN=100, no limit asserted):
  - motor_up high exactly 100 cycles, then 0 with fault=1, fault_code=1.
  - fault_clr → IDLE, fault_code=0.
- Limit conflict: both limits high during RUN_UP → next edge motor_up=0, FAULT, fault_code=2. fault_clr with both still high → re-enters FAULT.
- Stop in DEAD and in RUN_DN:
  - stop in DEAD → IDLE, no motor pulse.
  - stop in RUN_DN → motor_dn=0 next edge.
  - stop and activate together in IDLE → stays IDLE.
- Async reset during RUN_UP at cycle 20 → motor_up=0 immediately (before the next edge), state IDLE. After release, a new activate yields a full DEAD_TIME delay.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the up/down limit motor controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package motor_pkg;

    // Controller states. The encoding is visible on ctrl_state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD   = 3'd1,
        RUN_UP = 3'd2,
        RUN_DN = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // Latched direction of travel, chosen when leaving IDLE.
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_CONFLICT = 2'd2;

endpackage

// File: rtl/motor_ctrl_fsm_if.sv
// Command/status bundle between panel logic and the motor controller.
// Latency: n/a (wiring only).
// Backpressure: none; commands are level-sampled every cycle.
//
// master: panel/command side (drives commands and limit inputs, reads status)
// slave : motor controller (reads commands/limits, drives motor pins and status)
interface motor_ctrl_fsm_if;
    logic       activate;
    logic       stop;
    logic       up_limit;
    logic       dn_limit;
    logic       fault_clr;
    logic       motor_up;
    logic       motor_dn;
    logic [2:0] ctrl_state;
    logic       fault;
    logic [1:0] fault_code;
    logic       busy;

    modport master (
        output activate, stop, up_limit, dn_limit, fault_clr,
        input  motor_up, motor_dn, ctrl_state, fault, fault_code, busy
    );

    modport slave (
        input  activate, stop, up_limit, dn_limit, fault_clr,
        output motor_up, motor_dn, ctrl_state, fault, fault_code, busy
    );
endinterface

// File: rtl/motor_timer.sv
// Loadable down-counter shared by the dead-time and max-run phases.
// Latency: load/decrement take effect on the next clk edge; zero is a decode of the count.
// Backpressure: none; stops at zero instead of wrapping.
//
// Ports: clk, rst_n (async active-low), load (load value), en (decrement),
//        value (load value), zero (count is zero).
module motor_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/motor_ctrl_fsm.sv
// Bidirectional motor controller with dead-time, run timeout, stop, limit-conflict and sticky fault.
// Latency: activate sampled at edge T -> motor pin high from edge T+DEAD_TIME+1; all outputs registered.
// Backpressure: none; commands are level-sampled, FAULT ignores everything except fault_clr.
//
// Ports: clk, rst_n (async active-low), bus (motor_ctrl_fsm_if.slave):
//   activate/stop/up_limit/dn_limit/fault_clr in; motor_up/motor_dn/ctrl_state/fault/fault_code/busy out.
module motor_ctrl_fsm
    import motor_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DEAD_TIME = 4,
    parameter int MAX_RUN   = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_ctrl_fsm_if.slave   bus
);

    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(MAX_RUN - 1);

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [1:0] fc_q, fc_d;
    logic       up_q, up_d;
    logic       dn_q, dn_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             conflict;

    motor_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    assign conflict = bus.up_limit && bus.dn_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            fc_q    <= FC_NONE;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fc_q    <= fc_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    // Motor pins are computed from the next state so they switch on the same
    // edge as the state; they default low so any exit from RUN drops them.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        fc_d     = fc_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = DEAD_LD;

        case (state_q)
            IDLE: begin
                if (conflict) begin
                    state_d = FAULT;
                    fc_d    = FC_CONFLICT;
                end else if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.activate) begin
                    // Sitting on the top switch means the only way out is down.
                    dir_d    = bus.up_limit ? DIR_DN : DIR_UP;
                    tmr_load = 1'b1;
                    tmr_val  = DEAD_LD;
                    state_d  = DEAD;
                end
            end

            DEAD: begin
                if (conflict) begin
                    state_d = FAULT;
                    fc_d    = FC_CONFLICT;
                end else if (bus.stop) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = RUN_LD;
                    if (dir_q == DIR_DN) begin
                        state_d = RUN_DN;
                        dn_d    = 1'b1;
                    end else begin
                        state_d = RUN_UP;
                        up_d    = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end

            RUN_UP: begin
                if (conflict) begin
                    state_d = FAULT;
                    fc_d    = FC_CONFLICT;
                end else if (bus.up_limit || bus.stop) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = FAULT;
                    fc_d    = FC_TIMEOUT;
                end else begin
                    up_d   = 1'b1;
                    tmr_en = 1'b1;
                end
            end

            RUN_DN: begin
                if (conflict) begin
                    state_d = FAULT;
                    fc_d    = FC_CONFLICT;
                end else if (bus.dn_limit || bus.stop) begin
                    state_d = IDLE;
                end else if (tmr_zero) begin
                    state_d = FAULT;
                    fc_d    = FC_TIMEOUT;
                end else begin
                    dn_d   = 1'b1;
                    tmr_en = 1'b1;
                end
            end

            FAULT: begin
                // A persisting conflict is caught again from IDLE next cycle.
                if (bus.fault_clr) begin
                    state_d = IDLE;
                    fc_d    = FC_NONE;
                end
            end

            default: begin
                state_d = IDLE;
                fc_d    = FC_NONE;
            end
        endcase

        busy_d  = (state_d == DEAD) || (state_d == RUN_UP) || (state_d == RUN_DN);
        fault_d = (state_d == FAULT);
    end

    assign bus.motor_up   = up_q;
    assign bus.motor_dn   = dn_q;
    assign bus.ctrl_state = state_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fc_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_motor_ctrl_fsm.sv
// Directed bench for motor_ctrl_fsm: per-cycle vector table plus timeout and async-reset sequences.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_motor_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    motor_ctrl_fsm_if bus ();

    motor_ctrl_fsm #(
        .CNT_W     (16),
        .DEAD_TIME (4),
        .MAX_RUN   (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // {motor_up, motor_dn, ctrl_state[2:0], fault, fault_code[1:0], busy}
    logic [8:0] obs;
    assign obs = {bus.motor_up, bus.motor_dn, bus.ctrl_state, bus.fault, bus.fault_code, bus.busy};

    typedef struct {
        logic [4:0] ins;   // {activate, stop, up_limit, dn_limit, fault_clr}
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] ins, input logic mu, input logic md,
                                input logic [2:0] st, input logic flt, input logic [1:0] fc,
                                input logic bsy);
        vec_t v;
        v.ins = ins;
        v.exp = {mu, md, st, flt, fc, bsy};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got mu=%b md=%b st=%0d flt=%b fc=%0d busy=%b, expected mu=%b md=%b st=%0d flt=%b fc=%0d busy=%b",
                     nm, got[8], got[7], got[6:4], got[3], got[2:1], got[0],
                     exp[8], exp[7], exp[6:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Apply inputs between edges, let one rising edge happen, then sample.
    task automatic step(input logic [4:0] ins);
        @(negedge clk);
        {bus.activate, bus.stop, bus.up_limit, bus.dn_limit, bus.fault_clr} = ins;
        @(posedge clk);
        #1;
    endtask

    // Number of edges after the activate edge until a motor pin goes high (bounded).
    task automatic wait_motor(output int n);
        n = 0;
        while (!(bus.motor_up || bus.motor_dn) && n < 50) begin
            step(5'b00000);
            n++;
        end
    endtask

    initial begin
        int lat;
        int high;
        int cyc;

        {bus.activate, bus.stop, bus.up_limit, bus.dn_limit, bus.fault_clr} = 5'b00000;

        // Basic up move, opposite limit ignored, stop at top.
        vecs.push_back(mk(5'b10000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 1, 0, 3'd2, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 1, 0, 3'd2, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00010, 1, 0, 3'd2, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00100, 0, 0, 3'd0, 0, 2'd0, 0));
        // Down move from the top switch.
        vecs.push_back(mk(5'b10100, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00100, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00100, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00100, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00100, 0, 1, 3'd3, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 1, 3'd3, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00010, 0, 0, 3'd0, 0, 2'd0, 0));
        // stop beats activate in IDLE; stop in DEAD.
        vecs.push_back(mk(5'b11000, 0, 0, 3'd0, 0, 2'd0, 0));
        vecs.push_back(mk(5'b10000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b01000, 0, 0, 3'd0, 0, 2'd0, 0));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd0, 0, 2'd0, 0));
        // stop in RUN_DN.
        vecs.push_back(mk(5'b10100, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 1, 3'd3, 0, 2'd0, 1));
        vecs.push_back(mk(5'b01000, 0, 0, 3'd0, 0, 2'd0, 0));
        // Conflict in RUN_UP, FAULT ignores activate/stop, clear with conflict held re-faults.
        vecs.push_back(mk(5'b10000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00000, 1, 0, 3'd2, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00110, 0, 0, 3'd4, 1, 2'd2, 0));
        vecs.push_back(mk(5'b11110, 0, 0, 3'd4, 1, 2'd2, 0));
        vecs.push_back(mk(5'b00111, 0, 0, 3'd0, 0, 2'd0, 0));
        vecs.push_back(mk(5'b00110, 0, 0, 3'd4, 1, 2'd2, 0));
        vecs.push_back(mk(5'b00001, 0, 0, 3'd0, 0, 2'd0, 0));
        // Conflict in DEAD.
        vecs.push_back(mk(5'b10000, 0, 0, 3'd1, 0, 2'd0, 1));
        vecs.push_back(mk(5'b00110, 0, 0, 3'd4, 1, 2'd2, 0));
        vecs.push_back(mk(5'b00001, 0, 0, 3'd0, 0, 2'd0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", obs, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ins);
            chk($sformatf("row%0d", i), obs, vecs[i].exp);
        end

        // Timeout: motor_up high for exactly MAX_RUN cycles, then FAULT code 1.
        step(5'b10000);
        wait_motor(lat);
        chk_int("timeout_latency", lat, 4);
        high = 0;
        cyc  = 0;
        while (bus.ctrl_state != 3'd4 && cyc < 300) begin
            if (bus.motor_up) high++;
            step(5'b00000);
            cyc++;
        end
        chk_int("timeout_high_cycles", high, 100);
        chk("timeout_fault", obs, {1'b0, 1'b0, 3'd4, 1'b1, 2'd1, 1'b0});
        step(5'b10000);
        chk("timeout_ignores_act", obs, {1'b0, 1'b0, 3'd4, 1'b1, 2'd1, 1'b0});
        step(5'b00001);
        chk("timeout_clear", obs, 9'b0);

        // Async reset mid RUN_UP drops the motor before the next edge.
        step(5'b10000);
        wait_motor(lat);
        chk_int("pre_reset_latency", lat, 4);
        step(5'b00000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", obs, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh start after reset gets the full dead-time.
        step(5'b10000);
        chk("post_reset_dead", obs, {1'b0, 1'b0, 3'd1, 1'b0, 2'd0, 1'b1});
        wait_motor(lat);
        chk_int("post_reset_latency", lat, 4);
        chk("post_reset_run", obs, {1'b1, 1'b0, 3'd2, 1'b0, 2'd0, 1'b1});
        step(5'b00100);
        chk("post_reset_stop_top", obs, 9'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
